// File: rtl/cia_timer_bank.sv
// Bank of NUM_TIMERS CIA-style down-counting interval timers sharing one byte-wide register port.
// Optional counter read snapshot is enabled by defining CIA_TIMER_BANK_SNAPSHOT_EN.
module cia_timer_bank #(
    parameter int unsigned NUM_TIMERS = 4,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_W     = $clog2(NUM_TIMERS) + 3
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  phi2_dn,
    input  logic                  we,
    input  logic                  rd,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [7:0]            data_i,
    output logic [7:0]            data_o,
    input  logic                  cnt_up,
    input  logic                  cnt,
    output logic [NUM_TIMERS-1:0] ufl,
    output logic [NUM_TIMERS-1:0] pb,
    output logic                  irq_n
);
    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0]      latch_q [NUM_TIMERS];
    logic [WIDTH-1:0]      latch_n [NUM_TIMERS];
    logic [WIDTH-1:0]      count_q [NUM_TIMERS];
    logic [WIDTH-1:0]      count_n [NUM_TIMERS];
    logic [7:0]            ctrl_q  [NUM_TIMERS];
    logic [7:0]            ctrl_n  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] flag_q, flag_n, tff_q, tff_n, pulse_q, pulse_n, pb_n;
    logic [NUM_TIMERS:0]   casc;
    logic [2:0]            off;
    logic [3:0]            ctl;
    logic                  hit, wr_hit, ctrl_wr, do_load, src, tick, uf, irq_c;
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
    logic [WIDTH-1:0]      snap_q [NUM_TIMERS];
    logic [WIDTH-1:0]      snap_n [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] snap_v_q, snap_v_n;
`endif

    assign off = addr[2:0];

    // Next-state logic; timers are walked in index order so cascaded underflows ripple in one clk.
    always_comb begin
        latch_n = latch_q;
        count_n = count_q;
        ctrl_n  = ctrl_q;
        flag_n  = flag_q;
        tff_n   = tff_q;
        pulse_n = pulse_q;
        pb_n    = '0;
        casc    = '0;
        hit     = 1'b0;
        wr_hit  = 1'b0;
        ctrl_wr = 1'b0;
        do_load = 1'b0;
        ctl     = '0;
        src     = 1'b0;
        tick    = 1'b0;
        uf      = 1'b0;
        irq_c   = 1'b0;
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
        snap_n   = snap_q;
        snap_v_n = snap_v_q;
`endif
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
            hit     = ((addr >> 3) == ADDR_W'(i));
            wr_hit  = we && hit;
            ctrl_wr = wr_hit && (off == 3'd4);
            do_load = ctrl_wr && data_i[4];
            ctl     = ctrl_wr ? data_i[3:0] : ctrl_q[i][3:0];
            case (ctl[3:2])
                2'b00:   src = 1'b1;
                2'b01:   src = cnt_up;
                2'b10:   src = casc[i];
                default: src = casc[i] && cnt;
            endcase
            tick      = phi2_dn && ctl[0] && !do_load && src;
            uf        = tick && (count_q[i] == '0);
            casc[i+1] = uf;
            if (tick) count_n[i] = uf ? latch_q[i] : count_q[i] - WIDTH'(1);

            for (int k = 0; k < int'(NB); k++)
                if (wr_hit && (off == 3'(k))) latch_n[i][8*k +: 8] = data_i;
            if (do_load)
                count_n[i] = latch_q[i];
            else if (wr_hit && (off == 3'(NB - 1)) && !ctrl_q[i][0])
                count_n[i] = latch_n[i];

            if (ctrl_wr)            ctrl_n[i] = {data_i[7:5], 1'b0, data_i[3:0]};
            else if (uf && ctl[1])  ctrl_n[i][0] = 1'b0;

            if (ctrl_wr && data_i[0] && !ctrl_q[i][0]) tff_n[i] = 1'b1;
            else if (uf)                               tff_n[i] = !tff_q[i];

            if (uf)           pulse_n[i] = 1'b1;
            else if (phi2_dn) pulse_n[i] = 1'b0;

            if (uf)                                flag_n[i] = 1'b1;
            else if (rd && hit && (off == 3'd5))   flag_n[i] = 1'b0;

            pb_n[i] = ctrl_n[i][6] && (ctrl_n[i][7] ? tff_n[i] : pulse_n[i]);
            irq_c   = irq_c || (flag_q[i] && ctrl_q[i][5]);
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
            if (rd && hit && (NB > 1)) begin
                if (off == 3'd0) begin
                    snap_n[i]   = count_q[i];
                    snap_v_n[i] = 1'b1;
                end else if (off == 3'(NB - 1)) begin
                    snap_v_n[i] = 1'b0;
                end
            end
`endif
        end
    end

    // Combinational read mux.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
            if ((addr >> 3) == ADDR_W'(i)) begin
                case (off)
                    3'd4:    data_o = ctrl_q[i];
                    3'd5:    data_o = {6'd0, ctrl_q[i][0], flag_q[i]};
                    default: begin
                        for (int k = 0; k < int'(NB); k++) begin
                            if (off == 3'(k)) begin
                                data_o = 8'(count_q[i] >> (8 * k));
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
                                if ((k != 0) && snap_v_q[i]) data_o = 8'(snap_q[i] >> (8 * k));
`endif
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < int'(NUM_TIMERS); i++) begin
                latch_q[i] <= '1;
                count_q[i] <= '1;
                ctrl_q[i]  <= '0;
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
                snap_q[i]  <= '0;
`endif
            end
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
            snap_v_q <= '0;
`endif
            flag_q  <= '0;
            tff_q   <= '0;
            pulse_q <= '0;
            ufl     <= '0;
            pb      <= '0;
            irq_n   <= 1'b1;
        end else begin
            latch_q <= latch_n;
            count_q <= count_n;
            ctrl_q  <= ctrl_n;
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
            snap_q   <= snap_n;
            snap_v_q <= snap_v_n;
`endif
            flag_q  <= flag_n;
            tff_q   <= tff_n;
            pulse_q <= pulse_n;
            ufl     <= casc[NUM_TIMERS:1];
            pb      <= pb_n;
            irq_n   <= !irq_c;
        end
    end
endmodule

// File: tb/tb_cia_timer_bank.sv
// Self-checking bench for cia_timer_bank: directed scenarios plus randomized traffic against a behavioural model.
module tb_cia_timer_bank;
    localparam int N  = 4;
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
    localparam int W  = 32;
`else
    localparam int W  = 16;
`endif
    localparam int NB = W / 8;
    localparam int AW = $clog2(N) + 3;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

    logic          clk = 1'b0, res_n = 1'b1, phi2_dn = 1'b0, we = 1'b0, rd = 1'b0;
    logic          cnt_up = 1'b0, cnt = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    data_i = '0;
    logic [7:0]    data_o;
    logic [N-1:0]  ufl, pb;
    logic          irq_n;
    int            checks = 0, errors = 0;

    cia_timer_bank #(.NUM_TIMERS(N), .WIDTH(W)) dut (
        .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .we(we), .rd(rd), .addr(addr),
        .data_i(data_i), .data_o(data_o), .cnt_up(cnt_up), .cnt(cnt),
        .ufl(ufl), .pb(pb), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    longint unsigned m_latch [N], m_count [N], m_snap [N];
    bit              m_start [N], m_one [N], m_ie [N], m_pbon [N], m_tog [N];
    bit              m_flag [N], m_tff [N], m_pulse [N], m_snv [N];
    int              m_mode [N];
    logic [N-1:0]    exp_ufl, exp_pb;
    logic            exp_irq_n;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_latch[i] = MASK; m_count[i] = MASK; m_snap[i] = 0;
            m_start[i] = 0; m_one[i] = 0; m_ie[i] = 0; m_pbon[i] = 0; m_tog[i] = 0;
            m_flag[i] = 0; m_tff[i] = 0; m_pulse[i] = 0; m_snv[i] = 0; m_mode[i] = 0;
        end
        exp_ufl = '0; exp_pb = '0; exp_irq_n = 1'b1;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        int t, o;
        logic [7:0] r;
        t = a / 8; o = a % 8; r = 8'h00;
        if (t < N) begin
            if (o < NB) begin
                r = 8'((m_count[t] >> (8 * o)) & 64'hFF);
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
                if (o > 0 && m_snv[t]) r = 8'((m_snap[t] >> (8 * o)) & 64'hFF);
`endif
            end else if (o == 4) begin
                r = {m_tog[t], m_pbon[t], m_ie[t], 1'b0, 2'(m_mode[t]), m_one[t], m_start[t]};
            end else if (o == 5) begin
                r = {6'd0, m_start[t], m_flag[t]};
            end
        end
        return r;
    endfunction

    // One clk of the specified behaviour, timers visited in order so cascades ripple.
    function automatic void model_update(input bit w, input bit r, input int a, input int d,
                                         input bit p, input bit cu, input bit c);
        int t, o, md;
        logic [7:0] db;
        bit prev, any_irq, cw, ld, st, one, st_old, act, go, uf;
        longint unsigned old_latch, old_count;
        t = a / 8; o = a % 8; db = 8'(d); prev = 0; any_irq = 0;
        for (int i = 0; i < N; i++) if (m_flag[i] && m_ie[i]) any_irq = 1;
        for (int i = 0; i < N; i++) begin
            cw = w && (t == i) && (o == 4);
            ld = cw && db[4];
            st_old = m_start[i];
            st  = cw ? db[0] : m_start[i];
            one = cw ? db[1] : m_one[i];
            md  = cw ? int'(db[3:2]) : m_mode[i];
            case (md)
                0:       act = 1;
                1:       act = cu;
                2:       act = (i > 0) && prev;
                default: act = (i > 0) && prev && c;
            endcase
            go = p && st && !ld && act;
            old_latch = m_latch[i]; old_count = m_count[i];
            uf = go && (old_count == 0);
            if (go) m_count[i] = uf ? old_latch : ((old_count - 1) & MASK);
            if (uf) begin
                m_flag[i] = 1; m_pulse[i] = 1; m_tff[i] = !m_tff[i];
                if (one && !cw) m_start[i] = 0;
            end else if (p) begin
                m_pulse[i] = 0;
            end
            if (cw) begin
                if (db[0] && !st_old) m_tff[i] = 1;
                m_start[i] = db[0]; m_one[i] = db[1]; m_mode[i] = int'(db[3:2]);
                m_ie[i] = db[5]; m_pbon[i] = db[6]; m_tog[i] = db[7];
                if (ld) m_count[i] = old_latch;
            end
            if (w && (t == i) && (o < NB)) begin
                m_latch[i] = (m_latch[i] & ~(64'hFF << (8 * o))) | (64'(db) << (8 * o));
                if ((o == NB - 1) && !st_old) m_count[i] = m_latch[i];
            end
            if (r && (t == i) && (o == 5) && !uf) m_flag[i] = 0;
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
            if (r && (t == i) && (NB > 1)) begin
                if (o == 0) begin m_snap[i] = old_count; m_snv[i] = 1; end
                else if (o == NB - 1) m_snv[i] = 0;
            end
`endif
            exp_ufl[i] = uf;
            prev = uf;
        end
        for (int i = 0; i < N; i++) exp_pb[i] = m_pbon[i] && (m_tog[i] ? m_tff[i] : m_pulse[i]);
        exp_irq_n = !any_irq;
    endfunction

    task automatic step(input bit w, input bit r, input int a, input int d,
                        input bit p, input bit cu, input bit c);
        @(negedge clk);
        we = w; rd = r; addr = AW'(a); data_i = 8'(d); phi2_dn = p; cnt_up = cu; cnt = c;
        model_update(w, r, a, d, p, cu, c);
        @(posedge clk);
        #1;
        we = 1'b0; rd = 1'b0; phi2_dn = 1'b0; cnt_up = 1'b0;
    endtask

    task automatic wr(input int a, input int d);  step(1, 0, a, d, 0, 0, 0); endtask
    task automatic idle();                        step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic tick();                        step(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic peek(input int a);             addr = AW'(a); #1; endtask

    task automatic load_latch(input int t, input int v);
        for (int k = 0; k < NB; k++) wr(t * 8 + k, (v >> (8 * k)) & 255);
    endtask

    task automatic test_reset();
        logic [7:0] hi_exp;
        @(posedge clk); #2;
        res_n = 1'b0; model_reset(); #1;
        checks++; if (ufl !== '0)    begin errors++; $display("FAIL reset_ufl got=%b exp=0", ufl); end
        checks++; if (pb !== '0)     begin errors++; $display("FAIL reset_pb got=%b exp=0", pb); end
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq got=%b exp=1", irq_n); end
        hi_exp = (NB > 3) ? 8'hFF : 8'h00;
        for (int t = 0; t < N; t++) begin
            peek(t * 8);
            checks++; if (data_o !== 8'hFF) begin errors++; $display("FAIL reset_cnt0 t=%0d got=%h exp=ff", t, data_o); end
            peek(t * 8 + 3);
            checks++; if (data_o !== hi_exp) begin errors++; $display("FAIL reset_cnt3 t=%0d got=%h exp=%h", t, data_o, hi_exp); end
            peek(t * 8 + 4);
            checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_ctrl t=%0d got=%h exp=00", t, data_o); end
            peek(t * 8 + 5);
            checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_stat t=%0d got=%h exp=00", t, data_o); end
        end
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_continuous();
        int seq [4] = '{2, 1, 0, 3};
        load_latch(0, 3);
        peek(0);
        checks++; if (data_o !== 8'd3) begin errors++; $display("FAIL cont_forceload got=%0d exp=3", data_o); end
        wr(4, 8'h01);
        for (int k = 0; k < 8; k++) begin
            idle(); idle(); idle();
            checks++; if (ufl[0] !== 1'b0) begin errors++; $display("FAIL cont_ufl_idle k=%0d got=%b exp=0", k, ufl[0]); end
            tick();
            checks++; if (ufl[0] !== (k % 4 == 3)) begin errors++; $display("FAIL cont_ufl k=%0d got=%b exp=%b", k, ufl[0], (k % 4 == 3)); end
            peek(0);
            checks++; if (data_o !== 8'(seq[k % 4])) begin errors++; $display("FAIL cont_count k=%0d got=%0d exp=%0d", k, data_o, seq[k % 4]); end
        end
        peek(5);
        checks++; if (data_o !== 8'h03) begin errors++; $display("FAIL cont_stat got=%h exp=03", data_o); end
    endtask

    task automatic test_oneshot();
        load_latch(1, 1);
        wr(12, 8'h23);
        tick(); idle();
        tick();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL os_irq_lag got=%b exp=1", irq_n); end
        idle();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL os_irq got=%b exp=0", irq_n); end
        peek(13);
        checks++; if (data_o !== 8'h01) begin errors++; $display("FAIL os_stat got=%h exp=01", data_o); end
        peek(8);
        checks++; if (data_o !== 8'h01) begin errors++; $display("FAIL os_count got=%h exp=01", data_o); end
        tick(); tick();
        peek(8);
        checks++; if (data_o !== 8'h01) begin errors++; $display("FAIL os_stopped got=%h exp=01", data_o); end
        step(0, 1, 13, 0, 0, 0, 0);
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL os_irq_hold got=%b exp=0", irq_n); end
        idle();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL os_irq_clear got=%b exp=1", irq_n); end
        peek(13);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL os_stat_clr got=%h exp=00", data_o); end
    endtask

    task automatic test_cascade();
        load_latch(0, 1);
        wr(4, 8'h01);
        load_latch(1, 2);
        wr(12, 8'h09);
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (ufl[1:0] !== {(n % 6 == 0), (n % 2 == 0)}) begin
                errors++; $display("FAIL casc_ufl n=%0d got=%b exp=%b", n, ufl[1:0], {(n % 6 == 0), (n % 2 == 0)});
            end
            idle();
        end
    endtask

    task automatic test_pb_toggle();
        load_latch(2, 0);
        wr(20, 8'hC1);
        checks++; if (pb[2] !== 1'b1) begin errors++; $display("FAIL pbt_start got=%b exp=1", pb[2]); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++; if (pb[2] !== (k % 2 == 0)) begin errors++; $display("FAIL pbt_tog k=%0d got=%b exp=%b", k, pb[2], (k % 2 == 0)); end
            checks++; if (ufl[2] !== 1'b1) begin errors++; $display("FAIL pbt_ufl k=%0d got=%b exp=1", k, ufl[2]); end
            idle();
        end
    endtask

    task automatic test_collision();
        load_latch(3, 5);
        wr(28, 8'h01);
        tick(); tick();
        peek(24);
        checks++; if (data_o !== 8'd3) begin errors++; $display("FAIL coll_pre got=%0d exp=3", data_o); end
        step(1, 0, 28, 8'h11, 1, 0, 0);
        checks++; if (ufl[3] !== 1'b0) begin errors++; $display("FAIL coll_ufl got=%b exp=0", ufl[3]); end
        peek(24);
        checks++; if (data_o !== 8'd5) begin errors++; $display("FAIL coll_load got=%0d exp=5", data_o); end
        wr(24, 0);
        peek(24);
        checks++; if (data_o !== 8'd5) begin errors++; $display("FAIL coll_noforce got=%0d exp=5", data_o); end
        wr(28, 8'h11);
        step(0, 1, 29, 0, 1, 0, 0);
        checks++; if (ufl[3] !== 1'b1) begin errors++; $display("FAIL coll_uf got=%b exp=1", ufl[3]); end
        peek(29);
        checks++; if (data_o !== 8'h03) begin errors++; $display("FAIL coll_setwins got=%h exp=03", data_o); end
    endtask

`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
    task automatic test_snapshot();
        load_latch(0, 32'h0000_0101);
        wr(4, 8'h01);
        step(0, 1, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        peek(0);
        checks++; if (data_o !== 8'hFE) begin errors++; $display("FAIL snap_b0 got=%h exp=fe", data_o); end
        peek(1);
        checks++; if (data_o !== 8'h01) begin errors++; $display("FAIL snap_b1 got=%h exp=01", data_o); end
        step(0, 1, 1, 0, 0, 0, 0);
        peek(2);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL snap_b2 got=%h exp=00", data_o); end
        step(0, 1, 3, 0, 0, 0, 0);
        peek(1);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL snap_release got=%h exp=00", data_o); end
    endtask
`endif

    task automatic test_random();
        bit p, cu, c, w, r;
        int a, d, act, pa;
        for (int t = 0; t < N; t++) begin
            load_latch(t, $urandom_range(0, 4));
            wr(t * 8 + 4, ($urandom_range(0, 255) & 8'hEF) | 1);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            p = ($urandom_range(0, 2) == 0);
            cu = p && $urandom_range(0, 1);
            c = $urandom_range(0, 1);
            act = $urandom_range(0, 15);
            a = $urandom_range(0, N * 8 - 1);
            w = 0; r = 0; d = 0;
            if (act == 0) begin
                w = 1;
                d = ((a % 8) == 0) ? $urandom_range(0, 6) : (($urandom_range(0, 7) == 0) ? 1 : 0);
            end else if (act == 1) begin
                r = 1;
            end else if (act == 2) begin
                w = 1; a = (a / 8) * 8 + 4; d = $urandom_range(0, 255);
            end
            step(w, r, a, d, p, cu, c);
            checks++; if (ufl !== exp_ufl)     begin errors++; $display("FAIL rnd_ufl cyc=%0d got=%b exp=%b", cyc, ufl, exp_ufl); end
            checks++; if (pb !== exp_pb)       begin errors++; $display("FAIL rnd_pb cyc=%0d got=%b exp=%b", cyc, pb, exp_pb); end
            checks++; if (irq_n !== exp_irq_n) begin errors++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", cyc, irq_n, exp_irq_n); end
            pa = $urandom_range(0, N * 8 - 1);
            peek(pa);
            checks++; if (data_o !== m_read(pa)) begin errors++; $display("FAIL rnd_read cyc=%0d addr=%0d got=%h exp=%h", cyc, pa, data_o, m_read(pa)); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();  test_continuous();
        test_reset();  test_oneshot();
        test_reset();  test_cascade();
        test_reset();  test_pb_toggle();
        test_reset();  test_collision();
`ifdef CIA_TIMER_BANK_SNAPSHOT_EN
        test_reset();  test_snapshot();
`endif
        test_reset();  test_random();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
